// File: rtl/box_motion_ctrl.sv
// Per-frame bouncing-box motion sequencer in the pixel clock domain.
// Computes next X then Y into shadow registers and publishes all of them on one edge.
module box_motion_ctrl #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int BOX_SIZE = 200,
  parameter int SPEED_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               step,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         frame_count
);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  state_t             state;
  logic [SPEED_W-1:0] spd_q;
  logic               step_pending;
  logic [9:0]         nx, ny;
  logic               ndx, ndy, nbx, nby;
  logic [10:0]        spd_ext;

  assign spd_ext = 11'(spd_q);

  // One axis step, returned as {bounce, new_dir, new_pos}; 11-bit sums never wrap.
  function automatic logic [11:0] axis_next(input logic [9:0]  pos,
                                            input logic        dir,
                                            input logic [10:0] s,
                                            input logic [10:0] res);
    logic [10:0] p;
    p = {1'b0, pos};
    if (!dir) begin
      if (p + 11'(BOX_SIZE) + s > res) axis_next = {1'b1, 1'b1, 10'(res - 11'(BOX_SIZE))};
      else                             axis_next = {1'b0, 1'b0, 10'(p + s)};
    end else begin
      if (p < s) axis_next = {1'b1, 1'b0, 10'd0};
      else       axis_next = {1'b0, 1'b1, 10'(p - s)};
    end
  endfunction

  // NOTE: every register here, shadows included, is cleared by the async reset so an
  // aborted update leaves no stale state; all assignments are non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      spd_q        <= '0;
      step_pending <= 1'b0;
      nx           <= '0;
      ny           <= '0;
      ndx          <= 1'b0;
      ndy          <= 1'b0;
      nbx          <= 1'b0;
      nby          <= 1'b0;
      pos_x        <= '0;
      pos_y        <= '0;
      dir_x        <= 1'b0;
      dir_y        <= 1'b0;
      bounce_x     <= 1'b0;
      bounce_y     <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      frame_count  <= '0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (step && pause)              step_pending <= 1'b1;
      if (frame_tick && state != IDLE) overrun     <= 1'b1;

      case (state)
        IDLE: begin
          // Consuming the step below overrides a step arriving in the same cycle.
          if (frame_tick && (!pause || step_pending)) begin
            spd_q        <= speed;
            step_pending <= 1'b0;
            busy         <= 1'b1;
            state        <= CALC_X;
          end
        end
        CALC_X: begin
          {nbx, ndx, nx} <= axis_next(pos_x, dir_x, spd_ext, 11'(H_RES));
          state          <= CALC_Y;
        end
        CALC_Y: begin
          {nby, ndy, ny} <= axis_next(pos_y, dir_y, spd_ext, 11'(V_RES));
          state          <= COMMIT;
        end
        COMMIT: begin
          pos_x       <= nx;
          pos_y       <= ny;
          dir_x       <= ndx;
          dir_y       <= ndy;
          bounce_x    <= nbx;
          bounce_y    <= nby;
          frame_count <= frame_count + 8'd1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/box_motion_ctrl.md
Name: box_motion_ctrl

Overview:
Per-frame motion sequencer for the bouncing-box VGA sprite. It runs in the pixel clock domain and replaces vsync-clocked position logic. Once per frame it computes the box's next X/Y position, direction and wall bounces. It publishes the new position to the renderer atomically, so the renderer never sees a half-updated position. Speed, pause and single-step come from the dedicated inputs.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
BOX_SIZE, 200, box edge length in pixels
SPEED_W, 4, width of speed input

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse, first cycle of vertical blanking (from sync generator)
speed  input  SPEED_W  pixels moved per frame on each axis
pause  input  1  level; 1 = freeze motion
step  input  1  one-cycle pulse; while paused, permits exactly one update
pos_x  output  10  box left edge, registered
pos_y  output  10  box top edge, registered
dir_x  output  1  0 = right, 1 = left
dir_y  output  1  0 = down, 1 = up
bounce_x  output  1  one-cycle pulse on X wall hit
bounce_y  output  1  one-cycle pulse on Y wall hit
busy  output  1  high while an update is in flight
overrun  output  1  sticky; frame_tick arrived while busy
frame_count  output  8  count of committed updates, wraps 255->0

Behaviour:
- Reset (async, rst_n=0): every output is 0. FSM goes to IDLE, speed shadow = 0, step_pending = 0.
- FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
- IDLE -> CALC_X when frame_tick=1 and (pause=0 or step_pending=1).
  - speed is sampled into the shadow register on that same cycle.
  - step_pending clears on that same cycle.
- CALC_X -> CALC_Y -> COMMIT -> IDLE, unconditionally, one cycle each.
- busy = 1 in CALC_X, CALC_Y and COMMIT.
- Timing, with the tick sampled at cycle 0:
  - pos_x, pos_y, dir_x, dir_y, bounce_x, bounce_y and frame_count all update together on the edge that ends COMMIT.
  - The new values are visible at cycle 4.
  - bounce_x and bounce_y are high only at cycle 4.
- Next-X calculation, done in CALC_X into shadow registers (11-bit arithmetic, no truncation):
  - dir_x = 0 and pos_x + BOX_SIZE + s > H_RES: nx = H_RES - BOX_SIZE, dir flips to 1, bounce_x set.
  - dir_x = 0 otherwise: nx = pos_x + s.
  - dir_x = 1 and pos_x < s: nx = 0, dir flips to 0, bounce_x set.
  - dir_x = 1 otherwise: nx = pos_x - s.
- Y is identical in CALC_Y, using V_RES, dir_y and bounce_y.
- Range invariant: pos_x is always in 0..H_RES-BOX_SIZE and pos_y in 0..V_RES-BOX_SIZE.
- s = 0: position unchanged, no bounce and no direction change. frame_count still increments.
- Pause:
  - pause=1 in IDLE: frame_tick is ignored and nothing changes.
  - pause rising during CALC_*/COMMIT: the in-flight update completes normally.
- Step:
  - step=1 while pause=1 sets step_pending, which holds until consumed. Multiple steps before a tick do not accumulate.
  - step while pause=0 is ignored.
- A frame_tick while busy=1 is ignored and sets overrun. overrun clears only on reset.
- A speed change mid-update has no effect until the next accepted tick.
- Reset asserted mid-update aborts the update. Outputs return to their reset values immediately.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, no ticks -> outputs stay 0.
- Normal motion: speed=5, pause=0, one tick -> busy high for cycles 1..3; pos_x=5, pos_y=5, frame_count=1 at cycle 4; no bounce pulses.
- Right-wall and bottom-wall bounce:
  - speed=5, tick from pos_x=435 -> 440, no bounce.
  - Next tick -> pos_x=440, dir_x=1, bounce_x high for exactly one cycle.
  - Y from 275 -> 280, then bounce at 280 with dir_y=1.
- Left/top bounce: dir_x=1, pos_x=3, speed=5, tick -> pos_x=0, dir_x=0, bounce_x=1. Y behaves the same from pos_y=2.
- Pause and step:
  - pause=1 with 3 ticks -> positions and frame_count unchanged.
  - Two step pulses, then 2 ticks -> exactly one update (+speed).
  - step with pause=0 -> no extra update.
- Overrun and reset abort:
  - Tick, then a second tick at cycle 2 -> single update, overrun=1 and sticky.
  - rst_n low at cycle 2 of an update -> all outputs 0 and FSM IDLE.
